// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag bundle for the pipelined ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SEQ  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   typedef enum logic [0:0] {
      StIdle,
      StMulRun
   } alu_state_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/opcode request channel and result/flag response channel of alu_pipe.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_neg;
   logic             out_carry;
   logic             out_ovf;
   logic             out_err;
   logic             busy;

   // Source/consumer side
   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_err,
             busy
   );

   // ALU side
   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_err,
             busy
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps total.
// prod is combinational and includes the current step, so it is final while done is high.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   mcand_q, mplier_q;
   logic [2*WIDTH-1:0] acc_q, partial;
   logic [CW-1:0]      cnt_q;

   // Partial product for the bit selected by the step counter
   always_comb begin
      partial = '0;
      if (mplier_q[cnt_q]) begin
         partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
      end
      prod = acc_q + partial;
      done = (cnt_q == CW'(WIDTH - 1));
   end

   // Operand capture on start; accumulate and advance until the last step, then hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (start) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (step && !done) begin
         acc_q <= prod;
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops at full rate,
// MUL iterates for WIDTH cycles and completes only when the output slot is free.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MUL_EN = 1
) (
   input logic        clk,
   input logic        rst_n,
   alu_pipe_if.slave  bus
);
   localparam int unsigned SHW = $clog2(WIDTH);

   alu_state_e         state_q, state_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   res_q, res_d;
   alu_flags_t         flags_q, flags_d;

   logic [WIDTH-1:0]   a, b, xb, alu_res;
   logic [WIDTH:0]     sum;
   logic [SHW-1:0]     shamt;
   logic               sub, slt, is_mul;
   alu_flags_t         alu_flags, mul_flags;
   logic               slot_free, in_ready, mul_start, mul_step, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   // Opcode decode and single-cycle datapath
   always_comb begin
      a         = bus.in_a;
      b         = bus.in_b;
      shamt     = b[SHW-1:0];
      sub       = (bus.in_op == OP_SUB);
      xb        = b ^ {WIDTH{sub}};
      sum       = {1'b0, a} + {1'b0, xb} + {{WIDTH{1'b0}}, sub};
      slt       = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : (a < b);
      alu_res   = '0;
      alu_flags = '0;
      is_mul    = 1'b0;
      case (bus.in_op)
         OP_ADD, OP_SUB: begin
            alu_res         = sum[WIDTH-1:0];
            alu_flags.carry = sum[WIDTH];
            alu_flags.ovf   = (a[WIDTH-1] == xb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
         OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         OP_MUL: begin
            if (MUL_EN != 0) begin
               is_mul = 1'b1;
            end else begin
               alu_flags.err = 1'b1;
            end
         end
         default: alu_flags.err = 1'b1;
      endcase
      alu_flags.zero = (alu_res == '0);
      alu_flags.neg  = alu_res[WIDTH-1];
   end

   // Flags for a finished multiply (carry marks a non-zero high half)
   always_comb begin
      mul_flags       = '0;
      mul_flags.carry = |mul_prod[2*WIDTH-1:WIDTH];
      mul_flags.zero  = (mul_prod[WIDTH-1:0] == '0);
      mul_flags.neg   = mul_prod[WIDTH-1];
   end

   if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(
         .WIDTH (WIDTH)
      ) u_mul (
         .clk   (clk),
         .rst_n (rst_n),
         .start (mul_start),
         .step  (mul_step),
         .a     (bus.in_a),
         .b     (bus.in_b),
         .done  (mul_done),
         .prod  (mul_prod)
      );
   end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
   end

   assign slot_free = !valid_q || bus.out_ready;
   assign in_ready  = (state_q == StIdle) && slot_free;
   assign mul_step  = (state_q == StMulRun);

   // Next-state: accept/issue, MUL completion, output slot load/drain
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q && !bus.out_ready;
      res_d     = res_q;
      flags_d   = flags_q;
      mul_start = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.in_valid && in_ready) begin
               if (is_mul) begin
                  mul_start = 1'b1;
                  state_d   = StMulRun;
               end else begin
                  res_d   = alu_res;
                  flags_d = alu_flags;
                  valid_d = 1'b1;
               end
            end
         end
         StMulRun: begin
            if (mul_done && slot_free) begin
               res_d   = mul_prod[WIDTH-1:0];
               flags_d = mul_flags;
               valid_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = valid_q;
   assign bus.out_result = res_q;
   assign bus.out_zero   = flags_q.zero;
   assign bus.out_neg    = flags_q.neg;
   assign bus.out_carry  = flags_q.carry;
   assign bus.out_ovf    = flags_q.ovf;
   assign bus.out_err    = flags_q.err;
   assign bus.busy       = (state_q == StMulRun);
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   alu_pipe_if #(.WIDTH(8)) bus ();

   alu_pipe #(
      .WIDTH  (8),
      .MUL_EN (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags packed as {zero, neg, carry, ovf, err}
   function automatic logic [4:0] flags();
      return {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf, bus.out_err};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   // Issue one op with out_ready=1, check the registered result one cycle later
   task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic [4:0] ef);
      drive(op, a, b);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_result"}, 32'(bus.out_result), 32'(er));
      check({tag, "_flags"}, 32'(flags()), 32'(ef));
      tick();
      check({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
   endtask

   logic [7:0] held_res;
   logic [4:0] held_flags;

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'h0;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("rst_outs", 32'({bus.out_valid, bus.out_result, flags(), bus.busy}), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      single("add_ovf", 4'b0000, 8'h7F, 8'h01, 8'h80, 5'b01010);

      // SUB then SEQ back to back: in_ready stays high while result drains
      drive(4'b0001, 8'h05, 8'h05);
      check("b2b_rdy0", 32'(bus.in_ready), 32'd1);
      tick();
      drive(4'b0111, 8'h05, 8'h05);
      check("b2b_rdy1", 32'(bus.in_ready), 32'd1);
      check("sub_res", 32'({bus.out_valid, bus.out_result}), 32'h100);
      check("sub_flags", 32'(flags()), 32'(5'b10100));
      tick();
      bus.in_valid = 1'b0;
      check("seq_res", 32'({bus.out_valid, bus.out_result}), 32'h101);
      check("seq_flags", 32'(flags()), 32'(5'b00000));
      tick();

      single("slt", 4'b0110, 8'hFE, 8'h01, 8'h01, 5'b00000);
      single("sltu", 4'b1000, 8'hFE, 8'h01, 8'h00, 5'b10000);
      single("sra", 4'b1011, 8'h80, 8'h03, 8'hF0, 5'b01000);
      single("sll", 4'b1001, 8'h01, 8'h0B, 8'h08, 5'b00000);
      single("srl", 4'b1010, 8'h80, 8'h07, 8'h01, 5'b00000);
      single("and", 4'b0011, 8'hF0, 8'h3C, 8'h30, 5'b00000);
      single("xor", 4'b0101, 8'hFF, 8'hFF, 8'h00, 5'b10000);
      single("illegal", 4'b1111, 8'h12, 8'h34, 8'h00, 5'b10001);
      single("illegal2", 4'b0010, 8'h12, 8'h34, 8'h00, 5'b10001);

      // MUL 0x10*0x11 = 0x110: busy for 8 cycles, result 8 cycles after accept
      drive(4'b1100, 8'h10, 8'h11);
      check("mul_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("mul_run%0d", i), 32'({bus.busy, bus.in_ready, bus.out_valid}), 32'b100);
         tick();
      end
      check("mul_done", 32'({bus.out_valid, bus.busy, bus.out_result}), 32'h210);
      check("mul_flags", 32'(flags()), 32'(5'b00100));
      tick();

      // Backpressure: ADD result held for 3 cycles, next op waits
      bus.out_ready = 1'b0;
      drive(4'b0000, 8'h01, 8'h02);
      tick();
      held_res   = bus.out_result;
      held_flags = flags();
      check("bp_first", 32'({bus.out_valid, held_res}), 32'h103);
      drive(4'b0100, 8'h0F, 8'hF0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_hold%0d", i),
               32'({bus.out_valid, bus.in_ready, bus.out_result, flags()}),
               32'({1'b1, 1'b0, 8'h03, 5'b00000}));
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("bp_next", 32'({bus.out_valid, bus.out_result, flags()}),
            32'({1'b1, 8'hFF, 5'b01000}));
      tick();

      // Reset in the middle of a MUL
      drive(4'b1100, 8'h0F, 8'h0F);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid_mul_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", 32'({bus.out_valid, bus.out_result, flags(), bus.busy}), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_rdy", 32'({bus.in_ready, bus.busy}), 32'b10);
      tick();
      single("add_after_rst", 4'b0000, 8'h01, 8'h01, 8'h02, 5'b00000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
